// File: rtl/ex_stage.sv
// Execute stage of the 5-stage in-order pipeline.
// Latches decoded operands from the decode stage through a valid/allowin handshake,
// evaluates the 12-op one-hot ALU, issues the data-SRAM request for ld.w/st.w and
// forwards pc, result and register-write info to the memory stage.
// Optional feature: define EX_FWD_EN to drive the ALU-result bypass bus ex_fwd_zip;
// without it the bus is tied to zero but the port stays for a fixed interface.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        ex_allowin,
  input  logic        id_to_ex_valid,
  input  logic [31:0] id_pc,
  input  logic [75:0] id_alu_data_zip,
  input  logic        id_res_from_mem,
  input  logic        id_mem_we,
  input  logic [31:0] id_rkd_value,
  input  logic [5:0]  id_rf_zip,
  input  logic        mem_allowin,
  output logic        ex_to_mem_valid,
  output logic [31:0] ex_pc,
  output logic        ex_res_from_mem,
  output logic [37:0] ex_rf_zip,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [37:0] ex_fwd_zip
);

  // Single-cycle ALU: an instruction is always ready to leave after one cycle.
  logic        ex_ready_go;
  logic        ex_valid;

  // Payload registers
  logic [31:0] pc_r;
  logic [11:0] alu_op_r;
  logic [31:0] src1_r;
  logic [31:0] src2_r;
  logic        res_from_mem_r;
  logic        mem_we_r;
  logic [31:0] rkd_value_r;
  logic        rf_we_r;
  logic [4:0]  rf_waddr_r;

  logic [31:0] alu_result;
  logic        sram_req_ok;

  assign ex_ready_go     = 1'b1;
  assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid & ex_ready_go;

  // Stage valid bit: refilled whenever the stage can accept, otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its neighbours, matching real flops.
      ex_valid <= id_to_ex_valid;
    end
  end

  // Payload capture: only a real handoff overwrites the payload, so a stalled
  // instruction keeps its operands stable under back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r           <= 32'h0;
      alu_op_r       <= 12'h0;
      src1_r         <= 32'h0;
      src2_r         <= 32'h0;
      res_from_mem_r <= 1'b0;
      mem_we_r       <= 1'b0;
      rkd_value_r    <= 32'h0;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= 5'h0;
    end else if (id_to_ex_valid && ex_allowin) begin
      pc_r           <= id_pc;
      alu_op_r       <= id_alu_data_zip[75:64];
      src1_r         <= id_alu_data_zip[63:32];
      src2_r         <= id_alu_data_zip[31:0];
      res_from_mem_r <= id_res_from_mem;
      mem_we_r       <= id_mem_we;
      rkd_value_r    <= id_rkd_value;
      rf_we_r        <= id_rf_zip[5];
      rf_waddr_r     <= id_rf_zip[4:0];
    end
  end

  // ALU datapath: one shared subtractor feeds sub, slt and sltu.
  logic [32:0] diff_full;
  logic [31:0] sub_res;
  logic        slt_bit;
  logic        sltu_bit;
  logic [4:0]  shamt;
  logic [31:0] sra_res;

  assign diff_full = {1'b0, src1_r} - {1'b0, src2_r};
  assign sub_res   = diff_full[31:0];
  assign sltu_bit  = diff_full[32];
  assign slt_bit   = (src1_r[31] & ~src2_r[31])
                   | (~(src1_r[31] ^ src2_r[31]) & sub_res[31]);
  assign shamt     = src2_r[4:0];
  assign sra_res   = $unsigned($signed(src1_r) >>> shamt);

  // One-hot result select; an empty op vector yields zero.
  always_comb begin
    // NOTE: assigning a default before any conditional update keeps this block
    // purely combinational; a missed path would otherwise infer a latch.
    alu_result = 32'h0;
    if (alu_op_r[0])  alu_result = alu_result | (src1_r + src2_r);
    if (alu_op_r[1])  alu_result = alu_result | sub_res;
    if (alu_op_r[2])  alu_result = alu_result | {31'h0, slt_bit};
    if (alu_op_r[3])  alu_result = alu_result | {31'h0, sltu_bit};
    if (alu_op_r[4])  alu_result = alu_result | (src1_r & src2_r);
    if (alu_op_r[5])  alu_result = alu_result | ~(src1_r | src2_r);
    if (alu_op_r[6])  alu_result = alu_result | (src1_r | src2_r);
    if (alu_op_r[7])  alu_result = alu_result | (src1_r ^ src2_r);
    if (alu_op_r[8])  alu_result = alu_result | (src1_r << shamt);
    if (alu_op_r[9])  alu_result = alu_result | (src1_r >> shamt);
    if (alu_op_r[10]) alu_result = alu_result | sra_res;
    if (alu_op_r[11]) alu_result = alu_result | src2_r;
  end

  // The SRAM read is synchronous, so the request fires only on the cycle the
  // instruction actually moves into the memory stage; a stall never repeats a store.
  assign sram_req_ok     = ex_to_mem_valid & mem_allowin;
  assign data_sram_en    = sram_req_ok & (res_from_mem_r | mem_we_r);
  assign data_sram_we    = {4{sram_req_ok & mem_we_r}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value_r;

  assign ex_pc           = pc_r;
  assign ex_res_from_mem = res_from_mem_r;
  assign ex_rf_zip       = {rf_we_r & ex_valid, rf_waddr_r, alu_result};

`ifdef EX_FWD_EN
  // Bypass only ALU results; load data is not available yet, and r0 is never written.
  assign ex_fwd_zip = {ex_valid & rf_we_r & ~res_from_mem_r & (rf_waddr_r != 5'd0),
                       rf_waddr_r, alu_result};
`else
  assign ex_fwd_zip = 38'h0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a behavioural stage model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_allowin;
  logic        id_to_ex_valid;
  logic [31:0] id_pc;
  logic [75:0] id_alu_data_zip;
  logic        id_res_from_mem;
  logic        id_mem_we;
  logic [31:0] id_rkd_value;
  logic [5:0]  id_rf_zip;
  logic        mem_allowin;
  logic        ex_to_mem_valid;
  logic [31:0] ex_pc;
  logic        ex_res_from_mem;
  logic [37:0] ex_rf_zip;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [37:0] ex_fwd_zip;

  int n_tests = 0;
  int n_fail  = 0;
  int store_cnt = 0;

  ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ex_allowin      (ex_allowin),
    .id_to_ex_valid  (id_to_ex_valid),
    .id_pc           (id_pc),
    .id_alu_data_zip (id_alu_data_zip),
    .id_res_from_mem (id_res_from_mem),
    .id_mem_we       (id_mem_we),
    .id_rkd_value    (id_rkd_value),
    .id_rf_zip       (id_rf_zip),
    .mem_allowin     (mem_allowin),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_pc           (ex_pc),
    .ex_res_from_mem (ex_res_from_mem),
    .ex_rf_zip       (ex_rf_zip),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_fwd_zip      (ex_fwd_zip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the op table.
  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    r  = 32'h0;
    sh = int'(b % 32);
    for (int i = 0; i < 12; i++) begin
      if (op[i]) begin
        case (i)
          0:  r = r | (a + b);
          1:  r = r | (a - b);
          2:  r = r | (($signed(a) < $signed(b)) ? 32'h1 : 32'h0);
          3:  r = r | ((a < b) ? 32'h1 : 32'h0);
          4:  r = r | (a & b);
          5:  r = r | ~(a | b);
          6:  r = r | (a | b);
          7:  r = r | (a ^ b);
          8:  r = r | (a << sh);
          9:  r = r | (a >> sh);
          10: r = r | $unsigned($signed(a) >>> sh);
          default: r = r | b;
        endcase
      end
    end
    return r;
  endfunction

  // Behavioural model of the stage contents.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 0, m_src1 = 0, m_src2 = 0, m_rkd = 0;
  logic [11:0] m_op = 0;
  logic        m_rfm = 0, m_mwe = 0, m_rfwe = 0;
  logic [4:0]  m_waddr = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc = 0; m_src1 = 0; m_src2 = 0; m_rkd = 0; m_op = 0;
      m_rfm = 0; m_mwe = 0; m_rfwe = 0; m_waddr = 0;
    end else if (!m_valid || mem_allowin) begin
      m_valid = id_to_ex_valid;
      if (id_to_ex_valid) begin
        m_pc    = id_pc;
        m_op    = id_alu_data_zip[75:64];
        m_src1  = id_alu_data_zip[63:32];
        m_src2  = id_alu_data_zip[31:0];
        m_rfm   = id_res_from_mem;
        m_mwe   = id_mem_we;
        m_rkd   = id_rkd_value;
        m_rfwe  = id_rf_zip[5];
        m_waddr = id_rf_zip[4:0];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("m_allowin", {63'h0, ex_allowin}, {63'h0, !m_valid || mem_allowin});
    check("m_to_mem_valid", {63'h0, ex_to_mem_valid}, {63'h0, m_valid});
    check("m_pc", {32'h0, ex_pc}, {32'h0, m_pc});
    check("m_res_from_mem", {63'h0, ex_res_from_mem}, {63'h0, m_rfm});
    check("m_rf_zip", {26'h0, ex_rf_zip},
          {26'h0, m_rfwe && m_valid, m_waddr, alu_ref(m_op, m_src1, m_src2)});
    check("m_sram_en", {63'h0, data_sram_en},
          {63'h0, m_valid && mem_allowin && (m_rfm || m_mwe)});
    check("m_sram_we", {60'h0, data_sram_we},
          {60'h0, (m_valid && mem_allowin && m_mwe) ? 4'hF : 4'h0});
    check("m_sram_addr", {32'h0, data_sram_addr}, {32'h0, alu_ref(m_op, m_src1, m_src2)});
    check("m_sram_wdata", {32'h0, data_sram_wdata}, {32'h0, m_rkd});
`ifdef EX_FWD_EN
    check("m_fwd", {26'h0, ex_fwd_zip},
          {26'h0, m_valid && m_rfwe && !m_rfm && (m_waddr != 0), m_waddr,
           alu_ref(m_op, m_src1, m_src2)});
`else
    check("m_fwd", {26'h0, ex_fwd_zip}, 64'h0);
`endif
  end

  always @(posedge clk) if (data_sram_we != 4'h0) store_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                     input logic rfm, input logic mwe, input logic [31:0] rkd,
                     input logic rfwe, input logic [4:0] wa, input logic [31:0] pc);
    id_to_ex_valid  = 1'b1;
    id_pc           = pc;
    id_alu_data_zip = {op, s1, s2};
    id_res_from_mem = rfm;
    id_mem_we       = mwe;
    id_rkd_value    = rkd;
    id_rf_zip       = {rfwe, wa};
  endtask

  // Back-to-back op stream with hand-computed results.
  logic [11:0] s_op  [8];
  logic [31:0] s_a   [8];
  logic [31:0] s_b   [8];
  logic [31:0] s_exp [8];

  initial begin
    s_op[0] = 12'h010; s_a[0] = 32'hF0F0_1234; s_b[0] = 32'h0FF0_FFFF; s_exp[0] = 32'h00F0_1234;
    s_op[1] = 12'h020; s_a[1] = 32'hF0F0_0000; s_b[1] = 32'h0000_00FF; s_exp[1] = 32'h0F0F_FF00;
    s_op[2] = 12'h040; s_a[2] = 32'h1200_0000; s_b[2] = 32'h0034_0056; s_exp[2] = 32'h1234_0056;
    s_op[3] = 12'h080; s_a[3] = 32'hFFFF_0000; s_b[3] = 32'h0F0F_0F0F; s_exp[3] = 32'hF0F0_0F0F;
    s_op[4] = 12'h100; s_a[4] = 32'h0000_0001; s_b[4] = 32'h0000_0024; s_exp[4] = 32'h0000_0010;
    s_op[5] = 12'h200; s_a[5] = 32'h8000_0000; s_b[5] = 32'h0000_00FF; s_exp[5] = 32'h0000_0001;
    s_op[6] = 12'h800; s_a[6] = 32'h1111_1111; s_b[6] = 32'hABCD_E000; s_exp[6] = 32'hABCD_E000;
    s_op[7] = 12'h002; s_a[7] = 32'h0000_0005; s_b[7] = 32'h0000_0007; s_exp[7] = 32'hFFFF_FFFE;
  end

  initial begin
    id_to_ex_valid = 0; id_pc = 0; id_alu_data_zip = 0; id_res_from_mem = 0;
    id_mem_we = 0; id_rkd_value = 0; id_rf_zip = 0; mem_allowin = 1;
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_allowin", {63'h0, ex_allowin}, 64'h1);
    check("rst_to_mem_valid", {63'h0, ex_to_mem_valid}, 64'h0);
    check("rst_sram_en", {63'h0, data_sram_en}, 64'h0);
    check("rst_sram_we", {60'h0, data_sram_we}, 64'h0);
    check("rst_rf_zip", {26'h0, ex_rf_zip}, 64'h0);
    check("rst_fwd", {26'h0, ex_fwd_zip}, 64'h0);
    cyc();
    reset = 1'b0;

    // add wraps to zero
    put(12'h001, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 5'd3, 32'h1C00_0000);
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
    check("add_rf_zip", {26'h0, ex_rf_zip}, {26'h0, 1'b1, 5'd3, 32'h0});
    check("add_valid", {63'h0, ex_to_mem_valid}, 64'h1);
    check("add_pc", {32'h0, ex_pc}, {32'h0, 32'h1C00_0000});

    // slt / sltu / sra, back to back
    cyc();
    put(12'h004, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 5'd4, 32'h1C00_0004);
    cyc();
    put(12'h008, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 5'd4, 32'h1C00_0008);
    @(negedge clk);
    check("slt", {32'h0, ex_rf_zip[31:0]}, 64'h1);
    cyc();
    put(12'h400, 32'h8000_0000, 32'd33, 0, 0, 0, 1, 5'd4, 32'h1C00_000C);
    @(negedge clk);
    check("sltu", {32'h0, ex_rf_zip[31:0]}, 64'h0);
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
    check("sra", {32'h0, ex_rf_zip[31:0]}, {32'h0, 32'hC000_0000});

    // st.w, free-flowing
    cyc();
    put(12'h001, 32'h1000, 32'h8, 0, 1, 32'hDEAD_BEEF, 0, 5'd0, 32'h1C00_0010);
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
    check("st_en", {63'h0, data_sram_en}, 64'h1);
    check("st_we", {60'h0, data_sram_we}, 64'hF);
    check("st_addr", {32'h0, data_sram_addr}, {32'h0, 32'h1008});
    check("st_wdata", {32'h0, data_sram_wdata}, {32'h0, 32'hDEAD_BEEF});
    cyc();
    @(negedge clk);
    check("st_we_after", {60'h0, data_sram_we}, 64'h0);
    check("st_en_after", {63'h0, data_sram_en}, 64'h0);

    // st.w under back-pressure, next instruction waiting on decode
    cyc();
    mem_allowin = 0;
    put(12'h001, 32'h2000, 32'h8, 0, 1, 32'h1234_5678, 0, 5'd0, 32'h1C00_0020);
    cyc();
    put(12'h001, 32'h7, 32'h9, 0, 0, 0, 1, 5'd9, 32'h1C00_0024);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_allowin", {63'h0, ex_allowin}, 64'h0);
      check("bp_we", {60'h0, data_sram_we}, 64'h0);
      check("bp_addr", {32'h0, data_sram_addr}, {32'h0, 32'h2008});
      check("bp_wdata", {32'h0, data_sram_wdata}, {32'h0, 32'h1234_5678});
      check("bp_pc", {32'h0, ex_pc}, {32'h0, 32'h1C00_0020});
      cyc();
    end
    mem_allowin = 1;
    @(negedge clk);
    check("bp_release_we", {60'h0, data_sram_we}, 64'hF);
    check("bp_release_allowin", {63'h0, ex_allowin}, 64'h1);
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
    check("bp_next_rf_zip", {26'h0, ex_rf_zip}, {26'h0, 1'b1, 5'd9, 32'h10});
    check("bp_next_we", {60'h0, data_sram_we}, 64'h0);

    // ld.w in flight when reset asserts
    cyc();
    put(12'h001, 32'h3000, 32'h4, 1, 0, 0, 1, 5'd7, 32'h1C00_0030);
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
    check("ld_en", {63'h0, data_sram_en}, 64'h1);
    check("ld_we", {60'h0, data_sram_we}, 64'h0);
    #2 reset = 1'b1;
    #1;
    check("ld_rst_valid", {63'h0, ex_to_mem_valid}, 64'h0);
    check("ld_rst_en", {63'h0, data_sram_en}, 64'h0);
    check("ld_rst_rf_zip", {26'h0, ex_rf_zip}, 64'h0);
    cyc();
    reset = 1'b0;

    // Bypass bus: ALU write, load, write to r0
    put(12'h001, 32'h100, 32'h23, 0, 0, 0, 1, 5'd5, 32'h1C00_0040);
    cyc();
    put(12'h001, 32'h40, 32'h4, 1, 0, 0, 1, 5'd6, 32'h1C00_0044);
    @(negedge clk);
`ifdef EX_FWD_EN
    check("fwd_alu", {26'h0, ex_fwd_zip}, {26'h0, 1'b1, 5'd5, 32'h123});
`else
    check("fwd_alu", {26'h0, ex_fwd_zip}, 64'h0);
`endif
    cyc();
    put(12'h001, 32'h1, 32'h2, 0, 0, 0, 1, 5'd0, 32'h1C00_0048);
    @(negedge clk);
`ifdef EX_FWD_EN
    check("fwd_ld", {26'h0, ex_fwd_zip}, {26'h0, 1'b0, 5'd6, 32'h44});
`else
    check("fwd_ld", {26'h0, ex_fwd_zip}, 64'h0);
`endif
    cyc();
    id_to_ex_valid = 0;
    @(negedge clk);
`ifdef EX_FWD_EN
    check("fwd_r0", {26'h0, ex_fwd_zip}, {26'h0, 1'b0, 5'd0, 32'h3});
`else
    check("fwd_r0", {26'h0, ex_fwd_zip}, 64'h0);
`endif

    // Remaining ops issued back to back with no bubble
    cyc();
    put(s_op[0], s_a[0], s_b[0], 0, 0, 0, 1, 5'd10, 32'h1C00_0100);
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i < 7)
        put(s_op[i+1], s_a[i+1], s_b[i+1], 0, 0, 0, 1, 5'(11 + i), 32'h1C00_0104 + 32'(4 * i));
      else
        id_to_ex_valid = 0;
      @(negedge clk);
      check("stream_result", {32'h0, ex_rf_zip[31:0]}, {32'h0, s_exp[i]});
      check("stream_valid", {63'h0, ex_to_mem_valid}, 64'h1);
      cyc();
    end

    @(negedge clk);
    check("store_count", 64'(store_cnt), 64'd2);
    check("idle_valid", {63'h0, ex_to_mem_valid}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
